bitonic_loader: RTL and testbench
=================================

BITONIC_LOADER -- requirements
Module: bitonic_loader

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one sort element.
- REQ-002 SHALL have parameter NUM_ELEMS, default 8: elements per block; power of two, at least 2.
- REQ-003 SHALL have parameter NODE_DWIDTH, default DATA_WIDTH*NUM_ELEMS: packed block width; any other value is illegal.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
- REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
- REQ-006 SHALL have port in_valid, input, 1 bit: upstream word present.
- REQ-007 SHALL have port in_data, input, DATA_WIDTH bits: upstream element.
- REQ-008 SHALL have port in_last, input, 1 bit: final word of a short block; used only under REQ-027.
- REQ-009 SHALL have port in_ready, output, 1 bit: loader accepts a word this cycle.
- REQ-010 SHALL have port valid, output, 1 bit: one-cycle block-issue strobe to the downstream sort node.
- REQ-011 SHALL have port data_out, output, NODE_DWIDTH bits: packed block to the node; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-012 SHALL have port done, input, 1 bit: completion strobe from the downstream node.
- REQ-013 SHALL have port busy, output, 1 bit: high in ISSUE and WAIT.
- REQ-014 SHALL have port count, output, $clog2(NUM_ELEMS)+1 bits: elements currently buffered.

Function
- REQ-015 SHALL implement three states, FILL, ISSUE and WAIT, with all outputs driven from registers or state decode.
- REQ-016 FILL behaviour SHALL be: in_ready=1, valid=0, busy=0.
- REQ-017 A word SHALL be accepted when in_valid=1 and in_ready=1; it is written to slot count and count increments.
- REQ-018 Accepting the word that brings count to NUM_ELEMS SHALL move the FSM to ISSUE on the next cycle.
- REQ-019 ISSUE SHALL last exactly one cycle with valid=1, in_ready=0 and data_out holding the full block; the FSM then moves to WAIT.
- REQ-020 Latency SHALL be exactly 1 cycle: last word accepted in cycle N gives valid=1 in cycle N+1.
- REQ-021 WAIT behaviour SHALL be: in_ready=0, valid=0, data_out held stable.
- REQ-022 done=1 in WAIT SHALL move the FSM to FILL and clear count to 0, and the next word is accepted no earlier than the following cycle.
- REQ-023 done SHALL be ignored in FILL and ISSUE; no state, count or data change.
- REQ-024 in_valid SHALL be ignored while in_ready=0; no word is dropped or duplicated, and upstream holds the word.
- REQ-025 count SHALL never exceed NUM_ELEMS and SHALL wrap only through WAIT→FILL.
- REQ-026 data_out slots not yet written in FILL SHALL keep their previous contents; only the block at the ISSUE cycle is meaningful.

Configuration
- REQ-027 With BITONIC_LOADER_PAD_EN defined, accepting a word with in_last=1 and count+1 < NUM_ELEMS SHALL fill all remaining slots with all-ones (sort to the top), set count to NUM_ELEMS, and enter ISSUE next cycle.
- REQ-028 With BITONIC_LOADER_PAD_EN defined, in_last=1 on the word that completes a full block SHALL behave as REQ-018.
- REQ-029 Without BITONIC_LOADER_PAD_EN, in_last SHALL be ignored, and only full blocks are issued.

Reset
- REQ-030 reset=1 at a rising edge SHALL force FILL, count=0, valid=0, busy=0, in_ready=1 and data_out=0 on the next cycle, from any state.
- REQ-031 reset SHALL take priority over in_valid, in_last and done in the same cycle; a word offered during reset is not accepted.
- REQ-032 A block interrupted mid-FILL, ISSUE or WAIT by reset SHALL be discarded, and no valid follows.

Verification
- REQ-033 Bench SHALL check a full block: NUM_ELEMS=8, DATA_WIDTH=8, words 0x07..0x00 on consecutive cycles → valid one cycle after the 8th accept; data_out=64'h0001020304050607; in_ready=0.
- REQ-034 Bench SHALL check the done return: done pulsed 1 cycle after valid → next cycle FILL, count=0, in_ready=1; a second block of 0x11 ×8 gives data_out=64'h1111111111111111.
- REQ-035 Bench SHALL check backpressure: in_valid held high through WAIT with done delayed 5 cycles → no accept in WAIT, count stays 8, exactly 8 words consumed per block.
- REQ-036 Bench SHALL check a spurious done: done=1 in FILL at count=3 → count stays 3, state stays FILL, valid stays 0.
- REQ-037 Bench SHALL check padding with the macro defined: words 0x05, 0x09, 0x02, the last with in_last=1 → valid next cycle; data_out=64'hFFFFFFFFFF020905; without the macro, no valid and count=3.
- REQ-038 Bench SHALL check reset mid-block: reset at count=5, then 8 words of 0xAA → exactly one valid; data_out=64'hAAAAAAAAAAAAAAAA.

Source files
------------

// File: rtl/bitonic_loader.sv
// bitonic_loader: gathers NUM_ELEMS words into a packed block and issues it to a sort node.
// Define BITONIC_LOADER_PAD_EN to let in_last close a short block, padding the rest with all-ones.
module bitonic_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_ELEMS   = 8,
    parameter int NODE_DWIDTH = DATA_WIDTH * NUM_ELEMS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         valid,
    output logic [NODE_DWIDTH-1:0]       data_out,
    input  logic                         done,
    output logic                         busy,
    output logic [$clog2(NUM_ELEMS):0]   count
);
    localparam int CW = $clog2(NUM_ELEMS) + 1;
    typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;
    state_t state, state_next;
    logic accept, full, pad;
    logic [CW-1:0] count_inc;
    assign accept    = in_valid && in_ready;
    assign count_inc = count + 1'b1;
    assign full      = count_inc == CW'(NUM_ELEMS);
`ifdef BITONIC_LOADER_PAD_EN
    assign pad = in_last && !full;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign pad = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end
    always_comb begin
        state_next = state == ISSUE ? WAIT
                   : state == WAIT  ? (done ? FILL : WAIT)
                   : (accept && (full || pad)) ? ISSUE : FILL;
    end
    always_comb begin
        in_ready = state == FILL;
        valid    = state == ISSUE;
        busy     = state != FILL;
    end
    // A padded block closes with every slot above the last word forced to all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            data_out <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                if (CW'(i) == count) data_out[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                else if (pad && CW'(i) > count) data_out[i*DATA_WIDTH +: DATA_WIDTH] <= '1;
            end
            count <= pad ? CW'(NUM_ELEMS) : count_inc;
        end else if (state == WAIT && done) begin
            count <= '0;
        end
    end
endmodule

// File: tb/tb_bitonic_loader.sv
// tb_bitonic_loader: scoreboard bench for bitonic_loader with 8 x 8-bit elements.
module tb_bitonic_loader;
    logic        clk = 0;
    logic        reset, in_valid, in_last, done;
    logic [7:0]  in_data;
    logic        in_ready, valid, busy;
    logic [63:0] data_out;
    logic [3:0]  count;
    logic [63:0] exp_q[$];
    int n_checks = 0, n_fail = 0, n_valid = 0, n_acc = 0;
    int v0, a0;

    bitonic_loader #(.DATA_WIDTH(8), .NUM_ELEMS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .valid(valid),
        .data_out(data_out), .done(done), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (in_valid && in_ready && !reset) n_acc++;
        if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected_valid", valid, 0);
            else check("block", data_out, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        in_valid = 1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        check("send_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic finish_block();
        done = 1; step(); done = 0;
        check("done_count", count, 0);
        check("done_ready", in_ready, 1);
        check("done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; in_valid = 0; in_last = 0; done = 0; in_data = 0;
        step(); step();
        reset = 0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_data", data_out, 0);
        // full block, descending words
        exp_q.push_back(64'h0001020304050607);
        for (int i = 7; i >= 0; i--) send(8'(i), 0);
        check("issue_valid", valid, 1);
        check("issue_ready", in_ready, 0);
        check("issue_data", data_out, 64'h0001020304050607);
        step();
        check("wait_valid", valid, 0);
        check("wait_busy", busy, 1);
        finish_block();
        // second block, then backpressure through a long WAIT
        exp_q.push_back(64'h1111111111111111);
        for (int i = 0; i < 8; i++) send(8'h11, 0);
        check("blk2_data", data_out, 64'h1111111111111111);
        in_valid = 1; in_data = 8'h22;
        a0 = n_acc;
        for (int i = 0; i < 5; i++) step();
        check("bp_ready", in_ready, 0);
        check("bp_count", count, 8);
        check("bp_no_accept", 64'(n_acc - a0), 0);
        finish_block();
        exp_q.push_back(64'h2222222222222222);
        for (int i = 0; i < 8; i++) send(8'h22, 0);
        check("bp_consumed", 64'(n_acc - a0), 8);
        step();
        finish_block();
        // spurious done in FILL
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        done = 1; step(); done = 0;
        check("spur_count", count, 3);
        check("spur_ready", in_ready, 1);
        check("spur_valid", valid, 0);
        // reset at count 5 with a word offered
        send(8'h04, 0); send(8'h05, 0);
        check("pre_rst_count", count, 5);
        v0 = n_valid;
        reset = 1; in_valid = 1; in_data = 8'h55;
        step();
        reset = 0; in_valid = 0;
        check("mid_rst_count", count, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.push_back(64'hAAAAAAAAAAAAAAAA);
        for (int i = 0; i < 8; i++) send(8'hAA, 0);
        check("aa_data", data_out, 64'hAAAAAAAAAAAAAAAA);
        step();
        check("aa_one_valid", 64'(n_valid - v0), 1);
        finish_block();
        // short block closed by in_last
        v0 = n_valid;
`ifdef BITONIC_LOADER_PAD_EN
        exp_q.push_back(64'hFFFFFFFFFF020905);
`endif
        send(8'h05, 0); send(8'h09, 0); send(8'h02, 1);
`ifdef BITONIC_LOADER_PAD_EN
        check("pad_valid", valid, 1);
        check("pad_data", data_out, 64'hFFFFFFFFFF020905);
        step();
        check("pad_count", count, 8);
        finish_block();
`else
        for (int i = 0; i < 4; i++) step();
        check("nopad_valid", 64'(n_valid - v0), 0);
        check("nopad_count", count, 3);
        check("nopad_ready", in_ready, 1);
`endif
        step();
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
